// File: rtl/fanout_pkg.sv
// Shared constants, mode encoding and helpers for the fanout fork block.
package fanout_pkg;

  localparam int unsigned FANOUT_NUM_CH = 7;
  localparam int unsigned FANOUT_DATA_W = 16;
  localparam int unsigned FANOUT_DEPTH  = 2;

  typedef enum logic {
    FANOUT_EAGER = 1'b0,
    FANOUT_LAZY  = 1'b1
  } fanout_mode_e;

  // Saturating 16-bit increment used by the drop counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fanout_fork_if.sv
// Upstream token handshake plus per-channel downstream handshake of the fork.
interface fanout_fork_if
  import fanout_pkg::*;
#(
  parameter int unsigned NUM_CH = FANOUT_NUM_CH,
  parameter int unsigned DATA_W = FANOUT_DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [NUM_CH-1:0] in_sel;
  logic [NUM_CH-1:0] out_valid;
  logic [NUM_CH-1:0] out_ready;
  logic [DATA_W-1:0] out_data;

  // Producer/consumer side (drives tokens, consumes channels).
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Fork side.
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fanout_fifo.sv
// Input buffer for the fork: DEPTH-entry FIFO, no bypass, async-reset pointers.
module fanout_fifo
  import fanout_pkg::*;
#(
  parameter int unsigned WIDTH = FANOUT_DATA_W + FANOUT_NUM_CH,
  parameter int unsigned DEPTH = FANOUT_DEPTH
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Next pointer/occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fanout_fork.sv
// Fans each buffered token out to its target channels, in EAGER or LAZY mode.
module fanout_fork
  import fanout_pkg::*;
#(
  parameter int unsigned NUM_CH = FANOUT_NUM_CH,
  parameter int unsigned DATA_W = FANOUT_DATA_W,
  parameter int unsigned DEPTH  = FANOUT_DEPTH
) (
  input  logic              CLK,
  input  logic              ASYNCRESET,
  input  logic              cfg_mode,
  input  logic [NUM_CH-1:0] cfg_en,
  fanout_fork_if.slave      bus,
  output logic [15:0]       drop_cnt,
  output logic              busy
);
  localparam int unsigned EW = DATA_W + NUM_CH;

  logic [EW-1:0]     wr_entry, head_entry;
  logic              fifo_full, fifo_empty;
  logic              head_valid, push, pop;
  logic [NUM_CH-1:0] head_tgt;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] fire, out_valid_d;
  logic              all_rdy;
  fanout_mode_e      mode_q, mode_eff;
  logic [15:0]       drop_q, drop_d;

  assign bus.in_ready = ~fifo_full & ~ASYNCRESET;
  assign push         = bus.in_valid & bus.in_ready;
  assign wr_entry     = {bus.in_data, bus.in_sel & cfg_en};
  assign head_valid   = ~fifo_empty;
  assign head_tgt     = head_entry[NUM_CH-1:0];
  assign bus.out_data = head_entry[EW-1:NUM_CH];
  assign bus.out_valid = out_valid_d;
  assign drop_cnt     = drop_q;
  assign busy         = head_valid;

  fanout_fifo #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .ASYNCRESET(ASYNCRESET),
    .push      (push),
    .wdata     (wr_entry),
    .pop       (pop),
    .rdata     (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Per-channel presentation and pop decision for the head token.
  // A partially delivered head (done != 0) always finishes under EAGER rules,
  // so a mode flip mid-token cannot cause a channel to see it twice.
  always_comb begin
    mode_eff    = (done_q != '0) ? FANOUT_EAGER : mode_q;
    all_rdy     = &(~head_tgt | bus.out_ready);
    out_valid_d = '0;
    fire        = '0;
    pop         = 1'b0;
    done_d      = done_q;
    if (head_valid) begin
      case (mode_eff)
        FANOUT_LAZY: begin
          out_valid_d = all_rdy ? head_tgt : '0;
          pop         = all_rdy;
          done_d      = '0;
        end
        default: begin
          out_valid_d = head_tgt & ~done_q;
          fire        = out_valid_d & bus.out_ready;
          pop         = ((head_tgt & ~(done_q | fire)) == '0);
          done_d      = pop ? '0 : (done_q | fire);
        end
      endcase
    end
    drop_d = (pop && head_tgt == '0) ? sat_inc16(drop_q) : drop_q;
  end

  // Delivery tracking, mode register and drop counter.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      done_q <= '0;
      mode_q <= FANOUT_EAGER;
      drop_q <= '0;
    end else begin
      done_q <= done_d;
      mode_q <= cfg_mode ? FANOUT_LAZY : FANOUT_EAGER;
      drop_q <= drop_d;
    end
  end

endmodule

// File: tb/tb_fanout_fork.sv
// Self-checking bench for fanout_fork: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_fanout_fork;
  localparam int unsigned NCH = 7;
  localparam int unsigned DW  = 16;
  localparam int unsigned DEP = 2;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [NCH-1:0] tgt;
  } ent_t;

  logic           CLK;
  logic           ASYNCRESET;
  logic           cfg_mode;
  logic [NCH-1:0] cfg_en;
  logic [15:0]    drop_cnt;
  logic           busy;

  fanout_fork_if #(.NUM_CH(NCH), .DATA_W(DW)) bus ();

  fanout_fork #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEP)) dut (
    .CLK       (CLK),
    .ASYNCRESET(ASYNCRESET),
    .cfg_mode  (cfg_mode),
    .cfg_en    (cfg_en),
    .bus       (bus),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  ent_t           mq[$];
  logic [NCH-1:0] m_delivered;
  logic           m_mode;
  logic [15:0]    m_drop;
  logic [NCH-1:0] e_ov, e_fire;
  logic           e_pop, e_hv, e_rdy, e_lazy, e_allok;
  int unsigned    e_left;
  ent_t           e_head;

  always @(negedge CLK) begin
    if (ASYNCRESET) begin
      mq.delete();
      m_delivered = '0;
      m_mode      = 1'b0;
      m_drop      = '0;
      chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_busy",      32'(busy),          32'd0);
      chk("rst_drop_cnt",  32'(drop_cnt),      32'd0);
    end else begin
      e_hv   = (mq.size() != 0);
      e_rdy  = (mq.size() < DEP);
      e_ov   = '0;
      e_fire = '0;
      e_pop  = 1'b0;
      e_head = '0;
      if (e_hv) begin
        e_head = mq[0];
        // Lazy only applies while nothing of the head has been delivered yet.
        e_lazy = m_mode && (m_delivered == '0);
        if (e_lazy) begin
          e_allok = 1'b1;
          for (int i = 0; i < NCH; i++)
            if (e_head.tgt[i] && !bus.out_ready[i]) e_allok = 1'b0;
          if (e_allok) begin
            e_ov  = e_head.tgt;
            e_pop = 1'b1;
          end
        end else begin
          e_left = 0;
          for (int i = 0; i < NCH; i++) begin
            if (e_head.tgt[i] && !m_delivered[i]) begin
              e_ov[i] = 1'b1;
              if (bus.out_ready[i]) e_fire[i] = 1'b1;
              else e_left++;
            end
          end
          e_pop = (e_left == 0);
        end
      end
      chk("in_ready",  32'(bus.in_ready),  32'(e_rdy));
      chk("out_valid", 32'(bus.out_valid), 32'(e_ov));
      chk("busy",      32'(busy),          32'(e_hv));
      chk("drop_cnt",  32'(drop_cnt),      32'(m_drop));
      if (e_hv) chk("out_data", 32'(bus.out_data), 32'(e_head.data));
      // advance model to the state after the coming rising edge
      if (e_pop) begin
        if (e_head.tgt == '0 && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        void'(mq.pop_front());
        m_delivered = '0;
      end else begin
        m_delivered = m_delivered | e_fire;
      end
      if (bus.in_valid && e_rdy) mq.push_back('{data: bus.in_data, tgt: bus.in_sel & cfg_en});
      m_mode = cfg_mode;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_sel   = '0;
  endtask

  task automatic offer(input logic [DW-1:0] d, input logic [NCH-1:0] s);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sel   = s;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    ASYNCRESET    = 1'b1;
    cfg_mode      = 1'b0;
    cfg_en        = 7'h7F;
    bus.out_ready = '0;
    idle_in();
    #1;
    chk("por_in_ready",  32'(bus.in_ready),  32'd0);
    chk("por_out_valid", 32'(bus.out_valid), 32'd0);
    chk("por_busy",      32'(busy),          32'd0);
    repeat (2) @(posedge CLK);
    #3 ASYNCRESET = 1'b0;
    #1 chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // EAGER: ch0 fires at once, ch2 three cycles later
    tick(); offer(16'hABCD, 7'h05); bus.out_ready = 7'h01;
    tick(); idle_in();
    #2 chk("e_c1_ov", 32'(bus.out_valid), 32'h05);
    chk("e_c1_data", 32'(bus.out_data), 32'hABCD);
    tick(); #2 chk("e_c2_ov", 32'(bus.out_valid), 32'h04);
    tick(); #2 chk("e_c3_ov", 32'(bus.out_valid), 32'h04);
    tick(); bus.out_ready = 7'h05;
    #2 chk("e_c4_ov", 32'(bus.out_valid), 32'h04);
    chk("e_c4_busy", 32'(busy), 32'd1);
    tick(); #2 chk("e_c5_ov", 32'(bus.out_valid), 32'h00);
    chk("e_c5_busy", 32'(busy), 32'd0);

    // LAZY: nothing presented until every target is ready
    cfg_mode = 1'b1;
    tick(); offer(16'hABCD, 7'h05); bus.out_ready = 7'h01;
    tick(); idle_in();
    #2 chk("l_c1_ov", 32'(bus.out_valid), 32'h00);
    tick(); #2 chk("l_c2_ov", 32'(bus.out_valid), 32'h00);
    tick(); #2 chk("l_c3_ov", 32'(bus.out_valid), 32'h00);
    tick(); bus.out_ready = 7'h05;
    #2 chk("l_c4_ov", 32'(bus.out_valid), 32'h05);
    tick(); #2 chk("l_c5_busy", 32'(busy), 32'd0);

    // Empty target after enable masking: dropped and counted
    cfg_mode = 1'b0; cfg_en = 7'h77;
    tick(); offer(16'h1111, 7'h08); bus.out_ready = 7'h7F;
    tick(); offer(16'h1234, 7'h01);
    #2 chk("d_c1_ov", 32'(bus.out_valid), 32'h00);
    chk("d_c1_drop", 32'(drop_cnt), 32'd0);
    chk("d_c1_busy", 32'(busy), 32'd1);
    tick(); idle_in();
    #2 chk("d_c2_drop", 32'(drop_cnt), 32'd1);
    chk("d_c2_ov", 32'(bus.out_valid), 32'h01);
    chk("d_c2_data", 32'(bus.out_data), 32'h1234);
    tick(); #2 chk("d_c3_busy", 32'(busy), 32'd0);

    // Back-to-back streaming, one token per cycle
    cfg_en = 7'h7F; bus.out_ready = 7'h7F;
    for (int k = 0; k < 8; k++) begin
      tick(); offer(16'h0100 + 16'(k), 7'h7F);
      #2 chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
      if (k > 0) begin
        chk("b2b_data", 32'(bus.out_data), 32'h0100 + 32'(k - 1));
        chk("b2b_ov", 32'(bus.out_valid), 32'h7F);
      end
    end
    tick(); idle_in();
    #2 chk("b2b_last_data", 32'(bus.out_data), 32'h0107);
    tick(); #2 chk("b2b_busy", 32'(busy), 32'd0);

    // Backpressure: buffer fills at two, no bypass on pop
    bus.out_ready = '0;
    tick(); offer(16'h0200, 7'h03);
    #2 chk("bp_c0_rdy", 32'(bus.in_ready), 32'd1);
    tick(); offer(16'h0201, 7'h03);
    #2 chk("bp_c1_rdy", 32'(bus.in_ready), 32'd1);
    tick(); offer(16'h0202, 7'h03);
    #2 chk("bp_c2_rdy", 32'(bus.in_ready), 32'd0);
    tick(); bus.out_ready = 7'h7F;
    #2 chk("bp_c3_rdy", 32'(bus.in_ready), 32'd0);
    chk("bp_c3_data", 32'(bus.out_data), 32'h0200);
    tick();
    #2 chk("bp_c4_rdy", 32'(bus.in_ready), 32'd1);
    chk("bp_c4_data", 32'(bus.out_data), 32'h0201);
    tick(); idle_in();
    #2 chk("bp_c5_data", 32'(bus.out_data), 32'h0202);
    tick(); #2 chk("bp_c6_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-token with ch0 already delivered
    bus.out_ready = 7'h01;
    tick(); offer(16'h0300, 7'h03);
    tick(); idle_in();
    #2 chk("ar_c1_ov", 32'(bus.out_valid), 32'h03);
    tick();
    #2 chk("ar_c2_ov", 32'(bus.out_valid), 32'h02);
    ASYNCRESET = 1'b1;
    #1 chk("ar_ov",       32'(bus.out_valid), 32'h00);
    chk("ar_busy",     32'(busy),          32'd0);
    chk("ar_in_ready", 32'(bus.in_ready),  32'd0);
    chk("ar_drop",     32'(drop_cnt),      32'd0);
    @(posedge CLK);
    #3 ASYNCRESET = 1'b0;
    #1 chk("ar_rel_ov", 32'(bus.out_valid), 32'h00);
    chk("ar_rel_rdy", 32'(bus.in_ready), 32'd1);
    tick(); #2 chk("ar_post_busy", 32'(busy), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      tick();
      if ($urandom_range(0, 99) < 60) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 16'($urandom);
        bus.in_sel   = ($urandom_range(0, 9) == 0) ? '0 : NCH'($urandom);
      end else begin
        idle_in();
      end
      for (int i = 0; i < NCH; i++) bus.out_ready[i] = ($urandom_range(0, 99) < 65);
      if ($urandom_range(0, 99) < 5) cfg_en = NCH'($urandom);
      if ($urandom_range(0, 99) < 3) cfg_mode = ~cfg_mode;
      if (n == 1000) begin
        #2 ASYNCRESET = 1'b1;
        @(posedge CLK);
        #3 ASYNCRESET = 1'b0;
      end
    end

    // Drain
    tick(); idle_in(); bus.out_ready = '1;
    repeat (6) tick();
    #2 chk("drain_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
